// File: rtl/sw_debounce_sync3.sv
// sw_debounce_sync3: synchronises a raw switch vector to clk, debounces it as a whole,
// and presents each newly stable value on datos with a one-cycle enable pulse.
module sw_debounce_sync3 #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] datos,
    output logic             enable,
    output logic             busy
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t                             state;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q;
    logic [WIDTH-1:0]                   s;
    logic [WIDTH-1:0]                   stable;
    logic [WIDTH-1:0]                   cand;
    logic [CNT_W-1:0]                   cnt;

    assign s    = sync_q[SYNC_STAGES-1];
    assign busy = state == COUNT;

    always_ff @(posedge clk or negedge reset)
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};

    // A bounce back to the committed value wins over a restart, which wins over a commit.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state  <= IDLE;
            stable <= '0;
            cand   <= '0;
            cnt    <= '0;
            datos  <= '0;
            enable <= 1'b0;
        end else begin
            enable <= 1'b0;
            if (state == IDLE) begin
                if (s != stable) begin
                    state <= COUNT;
                    cand  <= s;
                    cnt   <= '0;
                end
            end else if (s == stable) begin
                state <= IDLE;
            end else if (s != cand) begin
                cand <= s;
                cnt  <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES-1)) begin
                stable <= cand;
                datos  <= cand;
                enable <= 1'b1;
                state  <= IDLE;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_sw_debounce_sync3.sv
// tb_sw_debounce_sync3: directed scenarios plus random switch activity, checked every cycle
// against a model stating the debounce rule as "N+1 consecutive synchronised samples of a new value".
module tb_sw_debounce_sync3;
    localparam int W  = 3;
    localparam int SY = 2;
    localparam int N  = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] datos;
    logic         enable;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] stable_m, last_s;
    int           run;
    logic         exp_en, exp_busy;
    int           edge_n, pulses, last_pulse, busy_n;

    sw_debounce_sync3 #(.WIDTH(W), .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in), .datos(datos), .enable(enable), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q = {};
        repeat (SY) q.push_back('0);
        stable_m = '0;
        last_s   = '0;
        run      = 0;
        exp_en   = 1'b0;
        exp_busy = 1'b0;
    endtask

    task automatic mark();
        edge_n = -1; pulses = 0; last_pulse = -1; busy_n = 0;
    endtask

    // A value commits once s has shown it on N+1 consecutive edges while it differs from the committed value.
    task automatic tick();
        logic [W-1:0] s;
        @(posedge clk);
        if (!reset) model_reset();
        else begin
            s = q.pop_front();
            q.push_back(sw_in);
            run    = (s == last_s) ? run + 1 : 1;
            last_s = s;
            exp_en = (s != stable_m) && (run == N + 1);
            if (exp_en) stable_m = s;
            exp_busy = s != stable_m;
        end
        #1;
        edge_n++;
        if (enable) begin pulses++; last_pulse = edge_n; end
        if (busy) busy_n++;
        chk("enable", enable, exp_en);
        chk("datos", datos, stable_m);
        chk("busy", busy, exp_busy);
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        sw_in = v;
        repeat (n) tick();
    endtask

    task automatic async_reset(input int n);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_datos", datos, 0);
        chk("rst_enable", enable, 0);
        chk("rst_busy", busy, 0);
        repeat (n) tick();
        reset = 1'b1;
    endtask

    initial begin
        int p1;
        model_reset();
        mark();
        // 1: reset held with 101 on the inputs, then a full debounce after release
        sw_in = 3'b101;
        reset = 1'b0;
        #1;
        chk("t1_rst_datos", datos, 0);
        chk("t1_rst_busy", busy, 0);
        repeat (5) tick();
        reset = 1'b1;
        mark();
        hold(3'b101, 14);
        chk("t1_pulses", pulses, 1);
        chk("t1_edge", last_pulse, SY + N);
        chk("t1_busy_cycles", busy_n, N);
        chk("t1_datos", datos, 3'b101);

        // 2: bouncing 011/000 every 3 cycles, then settle on 011
        async_reset(2);
        hold(3'b000, 3);
        mark();
        for (int i = 0; i < 8; i++) hold(i[0] ? 3'b000 : 3'b011, 3);
        chk("t2_no_pulse_bounce", pulses, 0);
        mark();
        hold(3'b011, 14);
        chk("t2_pulses", pulses, 1);
        chk("t2_edge", last_pulse, SY + N);
        chk("t2_datos", datos, 3'b011);

        // 3: short excursion to 100 never commits
        async_reset(2);
        hold(3'b000, 3);
        mark();
        hold(3'b100, 5);
        hold(3'b000, 12);
        chk("t3_pulses", pulses, 0);
        chk("t3_datos", datos, 0);
        chk("t3_busy_cycles", busy_n, 5);

        // 4: 001 glitch replaced by 010 before timing completes
        async_reset(2);
        hold(3'b000, 3);
        hold(3'b001, 4);
        mark();
        hold(3'b010, 14);
        chk("t4_pulses", pulses, 1);
        chk("t4_edge", last_pulse, SY + N);
        chk("t4_datos", datos, 3'b010);

        // 5: reset lands mid-count; candidate must be discarded
        async_reset(2);
        hold(3'b110, 7);
        chk("t5_busy_before", busy, 1);
        async_reset(3);
        mark();
        hold(3'b110, 14);
        chk("t5_pulses", pulses, 1);
        chk("t5_edge", last_pulse, SY + N);
        chk("t5_datos", datos, 3'b110);

        // 6: back-to-back commits 001 then 111
        async_reset(2);
        mark();
        sw_in = 3'b001;
        for (int i = 0; i < 30 && pulses == 0; i++) tick();
        chk("t6_first_pulse", pulses, 1);
        p1 = last_pulse;
        hold(3'b111, 16);
        chk("t6_pulses", pulses, 2);
        chk("t6_spacing_ok", (last_pulse - p1) >= N + 1, 1);
        chk("t6_datos", datos, 3'b111);

        // random activity with occasional resets
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 14) == 0) async_reset($urandom_range(1, 3));
            hold(W'($urandom_range(0, 7)), $urandom_range(1, 14));
        end
        hold(3'b000, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
